// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES datapath blocks (aes_core and its neighbours).
//   AES_BLK_W   : width of one AES block in bits
//   aes_block_t : one 128-bit AES block
//   idx_width() : width of a word index counter for a given word count (min 1)
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLK_W = 128;

   typedef logic [AES_BLK_W-1:0] aes_block_t;

   // A one-word block still needs a 1-bit counter so that the port and
   // register declarations never collapse to zero width.
   function automatic int idx_width(input int nwords);
      return (nwords > 1) ? $clog2(nwords) : 1;
   endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// ---------------------------------------------------------------------------
// aes_blk_fifo
// Small FIFO of whole AES blocks sitting between aes_core and the word
// serializer. The caller is responsible for only pushing when there is room
// (or when a pop happens in the same cycle).
// Parameters:
//   DEPTH    number of 128-bit entries, power of two, >= 2
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous active-high reset (pointers and count cleared)
//   push     write wr_data at the write pointer
//   pop      retire the head entry
//   wr_data  block to write
//   rd_data  head entry (valid when empty = 0)
//   full     count == DEPTH
//   empty    count == 0
// ---------------------------------------------------------------------------
module aes_blk_fifo
   import aes_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  aes_block_t wr_data,
   output aes_block_t rd_data,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   aes_block_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // Block storage. No reset on the array itself: stale entries are never
   // visible because the serializer only looks at the head when not empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
   // push and pop leaves the occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/aes_block_serializer.sv
// ---------------------------------------------------------------------------
// aes_block_serializer
// Captures 128-bit ciphertext blocks from aes_core into a small block FIFO
// and streams them MSB-first as OUT_W-bit words over valid/ready to the
// OFDM mapper. aes_core cannot be stalled, so blk_space is fed back at top
// level to gate its data_ready; a block that still arrives while the FIFO
// is full (and nothing retires) is dropped and flagged in ovf_err.
// Build option:
//   AES_SER_STATS_EN  when defined, adds the blk_count port and counter
// Parameters:
//   OUT_W      output word width, divides 128
//   DEPTH      block FIFO depth, power of two, >= 2
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   blk_valid  ciphertext block present (single-cycle pulse)
//   blk_data   ciphertext block
//   blk_space  at least one free FIFO entry
//   ovf_err    sticky overflow flag, cleared only by rst
//   out_valid  out_data holds a valid word
//   out_data   current word
//   out_last   current word is the last word of its block
//   out_ready  downstream accepts the word this cycle
//   blk_count  (AES_SER_STATS_EN) number of blocks fully emitted, wraps
// ---------------------------------------------------------------------------
module aes_block_serializer
   import aes_pkg::*;
#(
   parameter int OUT_W = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             blk_valid,
   input  aes_block_t       blk_data,
   output logic             blk_space,
   output logic             ovf_err,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready
`ifdef AES_SER_STATS_EN
   ,
   output logic [31:0]      blk_count
`endif
);

   localparam int NWORDS = AES_BLK_W / OUT_W;
   localparam int IDX_W  = idx_width(NWORDS);

   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             fire;
   logic             is_last;
   aes_block_t       head;
   logic [IDX_W-1:0] idx;
   logic [OUT_W-1:0] words [NWORDS];

   aes_blk_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (blk_data),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Slice the head block into words, word 0 being the most significant.
   for (genvar k = 0; k < NWORDS; k++) begin : g_words
      assign words[k] = head[AES_BLK_W-1-k*OUT_W -: OUT_W];
   end

   // Handshake and FIFO control. A block retires when its last word is
   // accepted; that retirement frees a slot in the same cycle, so an
   // arriving block is still taken even when the FIFO is full.
   always_comb begin
      out_valid = !fifo_empty;
      fire      = out_valid && out_ready;
      is_last   = (idx == IDX_W'(NWORDS - 1));
      out_last  = out_valid && is_last;
      pop       = fire && is_last;
      push      = blk_valid && (!fifo_full || pop);
      blk_space = !fifo_full;
      out_data  = out_valid ? words[idx] : '0;
   end

   // Word index within the head block. It only moves on an accepted word,
   // so everything presented downstream is frozen while out_ready is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (pop) begin
         idx <= '0;
      end else if (fire) begin
         idx <= idx + 1'b1;
      end
   end

   // Overflow is sticky: once a block has been lost the stream is corrupt
   // until the whole chain is reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err <= 1'b0;
      end else if (blk_valid && fifo_full && !pop) begin
         ovf_err <= 1'b1;
      end
   end

`ifdef AES_SER_STATS_EN
   // Count of completely emitted blocks, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_count <= '0;
      end else if (pop) begin
         blk_count <= blk_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_block_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_serializer
// Scoreboard bench for aes_block_serializer. The driver issues one cycle of
// stimulus at a time and, for each accepted block, queues the words the
// block must produce. A separate monitor compares the DUT against the head
// of that queue on every falling edge.
// ---------------------------------------------------------------------------
module tb_aes_block_serializer;
   import aes_pkg::*;

   localparam int OUT_W  = 8;
   localparam int DEPTH  = 2;
   localparam int NWORDS = AES_BLK_W / OUT_W;

   typedef struct {
      logic [OUT_W-1:0] data;
      bit               last;
   } word_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             blk_valid = 1'b0;
   aes_block_t       blk_data = '0;
   logic             out_ready = 1'b0;
   logic             blk_space;
   logic             ovf_err;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             out_last;
`ifdef AES_SER_STATS_EN
   logic [31:0]      blk_count;
`endif

   word_t       exp_q [$];
   bit          exp_ovf = 1'b0;
   int unsigned exp_blk_count = 0;
   bit          pop_now = 1'b0;
   bit          mon_en = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   aes_block_serializer #(
      .OUT_W (OUT_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .blk_valid (blk_valid),
      .blk_data  (blk_data),
      .blk_space (blk_space),
      .ovf_err   (ovf_err),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
`ifdef AES_SER_STATS_EN
      ,
      .blk_count (blk_count)
`endif
   );

   always #5 clk = ~clk;

   // Single comparison point: every check is counted here.
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Number of whole blocks the reference FIFO still holds.
   function automatic int blocks_held();
      int n = 0;
      foreach (exp_q[i]) begin
         if (exp_q[i].last) n++;
      end
      return n;
   endfunction

   // Reference: a block is simply its 128 bits cut into words, high end first.
   task automatic model_push(input aes_block_t b);
      word_t w;
      for (int k = 0; k < NWORDS; k++) begin
         w.data = OUT_W'(b >> ((NWORDS - 1 - k) * OUT_W));
         w.last = (k == NWORDS - 1);
         exp_q.push_back(w);
      end
   endtask

   // Monitor body, run on each falling edge with inputs and outputs stable.
   task automatic check_output();
      bit    ev;
      word_t w;
      ev      = (exp_q.size() != 0);
      pop_now = 1'b0;
      check("out_valid", out_valid, ev);
      check("blk_space", blk_space, blocks_held() < DEPTH);
      check("ovf_err", ovf_err, exp_ovf);
`ifdef AES_SER_STATS_EN
      check("blk_count", blk_count, exp_blk_count);
`endif
      if (ev) begin
         w = exp_q[0];
         check("out_data", out_data, w.data);
         check("out_last", out_last, w.last);
         if (out_ready && !rst) begin
            void'(exp_q.pop_front());
            if (w.last) begin
               pop_now = 1'b1;
               exp_blk_count++;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) check_output();
      end
   end

   // One clock of stimulus, entered and left 1 time unit after a rising edge.
   // The reference decides acceptance after the monitor has seen whether the
   // head block retires on the same edge.
   task automatic apply_stimulus(input bit v, input aes_block_t d, input bit r, input bit rs);
      int held;
      blk_valid = v;
      blk_data  = d;
      out_ready = r;
      rst       = rs;
      @(negedge clk);
      #1;
      if (rs) begin
         exp_q.delete();
         exp_ovf       = 1'b0;
         exp_blk_count = 0;
      end else if (v) begin
         held = blocks_held() + (pop_now ? 1 : 0);
         if (held < DEPTH || pop_now) model_push(d);
         else exp_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
   endtask

   task automatic run_idle(input int n, input bit r);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, r, 1'b0);
   endtask

   task automatic run_toggle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, (i % 2) == 0, 1'b0);
   endtask

   task automatic check_reset_state();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_blk_space", blk_space, 1'b1);
      check("rst_ovf_err", ovf_err, 1'b0);
`ifdef AES_SER_STATS_EN
      check("rst_blk_count", blk_count, 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      aes_block_t b0, b1, b2, rb;
      bit         v, r;
      b0 = 128'h3925841d02dc09fbdc118597196a0b32;
      b1 = 128'h00112233445566778899aabbccddeeff;
      b2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

      @(posedge clk);
      #1;
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_reset_state();
      mon_en = 1'b1;

      $display("[TB] single block, ready high");
      apply_stimulus(1'b1, b0, 1'b1, 1'b0);
      run_idle(18, 1'b1);

      $display("[TB] backpressure, ready toggling");
      apply_stimulus(1'b1, b0, 1'b1, 1'b0);
      run_toggle(36);

      $display("[TB] fill and overflow");
      apply_stimulus(1'b1, b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, b1, 1'b0, 1'b0);
      run_idle(2, 1'b0);
      apply_stimulus(1'b1, b2, 1'b0, 1'b0);
      run_idle(2, 1'b0);
      run_idle(36, 1'b1);

      $display("[TB] reset clears overflow");
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_reset_state();

      $display("[TB] full with simultaneous pop");
      apply_stimulus(1'b1, b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, b1, 1'b0, 1'b0);
      run_idle(2, 1'b0);
      run_idle(NWORDS - 1, 1'b1);
      apply_stimulus(1'b1, b2, 1'b1, 1'b0);
      run_idle(2 * NWORDS + 4, 1'b1);

      $display("[TB] reset mid-block");
      apply_stimulus(1'b1, b1, 1'b1, 1'b0);
      run_idle(5, 1'b1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b1);
      check_reset_state();
      apply_stimulus(1'b1, b2, 1'b1, 1'b0);
      run_idle(NWORDS + 2, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         v  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 3) != 0);
         rb = {$urandom, $urandom, $urandom, $urandom};
         apply_stimulus(v, rb, r, 1'b0);
      end
      run_idle(3 * NWORDS + 4, 1'b1);

      @(negedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
